muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide unit, parametrised in data width.
- Sits beside the combinational ALU in the execute stage.
- Accepts one operation through a valid/ready handshake, iterates one bit per cycle, then holds the result until the consumer accepts it.
- Adds MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU, including RISC-V divide-by-zero and overflow semantics, plus abort support.

---
 rtl/muldiv_unit_pkg.sv | 31 +++
 rtl/muldiv_step.sv | 47 ++++
 rtl/muldiv_unit.sv | 163 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// operation codes (RV32M funct3), FSM state encoding and operand-sign helpers.
package muldiv_unit_pkg;

   localparam logic [2:0] OP_MD_MUL    = 3'b000;
   localparam logic [2:0] OP_MD_MULH   = 3'b001;
   localparam logic [2:0] OP_MD_MULHSU = 3'b010;
   localparam logic [2:0] OP_MD_MULHU  = 3'b011;
   localparam logic [2:0] OP_MD_DIV    = 3'b100;
   localparam logic [2:0] OP_MD_DIVU   = 3'b101;
   localparam logic [2:0] OP_MD_REM    = 3'b110;
   localparam logic [2:0] OP_MD_REMU   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } md_state_e;

   // rs1 is treated as two's complement by these operations
   function automatic logic op_a_signed(input logic [2:0] op);
      return (op == OP_MD_MULH) || (op == OP_MD_MULHSU) ||
             (op == OP_MD_DIV)  || (op == OP_MD_REM);
   endfunction

   // rs2 is treated as two's complement by these operations
   function automatic logic op_b_signed(input logic [2:0] op);
      return (op == OP_MD_MULH) || (op == OP_MD_DIV) || (op == OP_MD_REM);
   endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide on unsigned magnitudes.
// A single WIDTH+1 bit adder is shared; divide feeds it the inverted divisor.
module muldiv_step #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             is_div,
   input  logic [WIDTH-1:0] hi,
   input  logic [WIDTH-1:0] lo,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi_next,
   output logic [WIDTH-1:0] lo_next
);

   localparam int unsigned AW = WIDTH + 1;
   localparam int unsigned SW = AW + 1;

   logic [AW-1:0] shifted;
   logic [AW-1:0] opa;
   logic [AW-1:0] opb;
   logic          cin;
   logic [SW-1:0] sum;
   logic          qbit;

   always_comb begin
      shifted = {hi, lo[WIDTH-1]};
      if (is_div) begin
         opa = shifted;
         opb = ~{1'b0, b};
         cin = 1'b1;
      end else begin
         opa = {1'b0, hi};
         opb = lo[0] ? {1'b0, b} : '0;
         cin = 1'b0;
      end
      sum  = {1'b0, opa} + {1'b0, opb} + SW'(cin);
      // carry out of the subtract means the shifted remainder was >= divisor
      qbit = sum[SW-1];
      if (is_div) begin
         hi_next = qbit ? sum[WIDTH-1:0] : shifted[WIDTH-1:0];
         lo_next = {lo[WIDTH-2:0], qbit};
      end else begin
         hi_next = sum[WIDTH:1];
         lo_next = {sum[0], lo[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: valid/ready request, one bit per cycle,
// result held until accepted; divide-by-zero/overflow resolved in one cycle.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [2:0]       i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_kill,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_c
);

   localparam int unsigned CNT_W = $clog2(WIDTH);
   localparam int unsigned PW    = 2 * WIDTH;
   localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   md_state_e        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       op_q, op_d;
   logic             neg_q, neg_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d, c_q, c_d;
   logic             ready_q, valid_q;

   logic [WIDTH-1:0] step_hi, step_lo;
   logic             a_sgn, b_sgn, b_zero, ovf, fast;
   logic [WIDTH-1:0] fast_res, final_res;
   logic [PW-1:0]    prod;

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div  (op_q[2]),
      .hi      (hi_q),
      .lo      (lo_q),
      .b       (b_q),
      .hi_next (step_hi),
      .lo_next (step_lo)
   );

   // Request decode: operand signs, fast-path detection and its result
   always_comb begin
      a_sgn    = op_a_signed(i_op) && i_a[WIDTH-1];
      b_sgn    = op_b_signed(i_op) && i_b[WIDTH-1];
      b_zero   = (i_b == '0);
      ovf      = (i_a == MIN_INT) && (i_b == '1);
      fast     = i_op[2] && (b_zero || (!i_op[0] && ovf));
      fast_res = '0;
      if (b_zero) begin
         fast_res = i_op[1] ? i_a : '1;
      end else if (!i_op[1]) begin
         fast_res = MIN_INT;
      end
   end

   // Sign fix-up of the final step, applied on the way into DONE
   always_comb begin
      prod = {step_hi, step_lo};
      if (neg_q) begin
         prod = -prod;
      end
      final_res = '0;
      if (!op_q[2]) begin
         final_res = (op_q == OP_MD_MUL) ? prod[WIDTH-1:0] : prod[PW-1:WIDTH];
      end else if (!op_q[1]) begin
         final_res = neg_q ? -step_lo : step_lo;
      end else begin
         final_res = neg_q ? -step_hi : step_hi;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      neg_d   = neg_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      b_d     = b_q;
      c_d     = c_q;
      unique case (state_q)
         ST_IDLE: begin
            if (i_valid) begin
               op_d  = i_op;
               neg_d = (i_op[2] && i_op[1]) ? a_sgn : (a_sgn ^ b_sgn);
               hi_d  = '0;
               lo_d  = a_sgn ? -i_a : i_a;
               b_d   = b_sgn ? -i_b : i_b;
               cnt_d = '0;
               if (fast) begin
                  c_d     = fast_res;
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_CALC;
               end
            end
         end
         ST_CALC: begin
            hi_d  = step_hi;
            lo_d  = step_lo;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
               c_d     = final_res;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            if (i_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // Flush wins over accept and handshake; the request is dropped entirely
      if (i_kill) begin
         state_d = ST_IDLE;
         cnt_d   = cnt_q;
         op_d    = op_q;
         neg_d   = neg_q;
         hi_d    = hi_q;
         lo_d    = lo_q;
         b_d     = b_q;
         c_d     = c_q;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         neg_q   <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         b_q     <= '0;
         c_q     <= '0;
         ready_q <= 1'b1;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         neg_q   <= neg_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         b_q     <= b_d;
         c_q     <= c_d;
         ready_q <= (state_d == ST_IDLE);
         valid_q <= (state_d == ST_DONE);
      end
   end

   assign o_ready = ready_q;
   assign o_valid = valid_q;
   assign o_c     = c_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit at WIDTH=32 and WIDTH=8.
module tb_muldiv_unit;

   localparam int unsigned W = 32;

   logic          i_clk = 1'b0;
   logic          i_rst_n;
   logic          i_valid, i_kill, i_ready;
   logic [2:0]    i_op;
   logic [W-1:0]  i_a, i_b;
   logic          o_ready, o_valid;
   logic [W-1:0]  o_c;

   logic          v8, k8, r8;
   logic [2:0]    op8;
   logic [7:0]    a8, b8;
   logic          o_ready8, o_valid8;
   logic [7:0]    o_c8;

   int n_cmp = 0;
   int n_err = 0;

   always #5 i_clk = ~i_clk;

   muldiv_unit #(.WIDTH(W)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_op(i_op), .i_a(i_a), .i_b(i_b), .i_kill(i_kill), .o_valid(o_valid),
      .i_ready(i_ready), .o_c(o_c)
   );

   muldiv_unit #(.WIDTH(8)) dut8 (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(v8), .o_ready(o_ready8),
      .i_op(op8), .i_a(a8), .i_b(b8), .i_kill(k8), .o_valid(o_valid8),
      .i_ready(r8), .o_c(o_c8)
   );

   // Issue one request; operands are scrambled after accept to prove they are ignored.
   // lat = number of clock edges after the accept edge until o_valid is seen.
   task automatic run32(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] res, output int lat);
      @(negedge i_clk);
      i_valid = 1'b1; i_op = op; i_a = a; i_b = b;
      @(posedge i_clk);
      @(negedge i_clk);
      i_valid = 1'b0; i_op = ~op; i_a = ~a; i_b = ~b;
      lat = 0;
      while (!o_valid && lat < 200) begin
         @(negedge i_clk);
         lat++;
      end
      res = o_c;
   endtask

   task automatic release32();
      @(negedge i_clk);
      i_ready = 1'b1;
      @(negedge i_clk);
      i_ready = 1'b0;
   endtask

   task automatic test_reset();
      n_cmp++;
      if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_c !== '0) begin
         n_err++;
         $display("FAIL reset32: ready=%b valid=%b c=%h expected 1 0 0", o_ready, o_valid, o_c);
      end
      n_cmp++;
      if (o_ready8 !== 1'b1 || o_valid8 !== 1'b0 || o_c8 !== '0) begin
         n_err++;
         $display("FAIL reset8: ready=%b valid=%b c=%h expected 1 0 0", o_ready8, o_valid8, o_c8);
      end
   endtask

   task automatic test_mul();
      logic [2:0]   ops [4] = '{3'b000, 3'b001, 3'b011, 3'b010};
      logic [W-1:0] va  [4] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [W-1:0] vb  [4] = '{32'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [W-1:0] exp [4] = '{32'h0000_002A, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
      logic [W-1:0] res;
      int lat;
      for (int i = 0; i < 4; i++) begin
         run32(ops[i], va[i], vb[i], res, lat);
         n_cmp++;
         if (res !== exp[i]) begin
            n_err++;
            $display("FAIL mul[%0d] result: got %h expected %h", i, res, exp[i]);
         end
         n_cmp++;
         if (lat !== 32) begin
            n_err++;
            $display("FAIL mul[%0d] latency: got %0d expected 32", i, lat);
         end
         release32();
      end
   endtask

   task automatic test_div();
      logic [2:0]   ops [4] = '{3'b100, 3'b110, 3'b101, 3'b111};
      logic [W-1:0] va  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
      logic [W-1:0] vb  [4] = '{32'd2, 32'd2, 32'd7, 32'd7};
      logic [W-1:0] exp [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h0000_000E, 32'h0000_0002};
      logic [W-1:0] res;
      int lat;
      for (int i = 0; i < 4; i++) begin
         run32(ops[i], va[i], vb[i], res, lat);
         n_cmp++;
         if (res !== exp[i]) begin
            n_err++;
            $display("FAIL div[%0d] result: got %h expected %h", i, res, exp[i]);
         end
         n_cmp++;
         if (lat !== 32) begin
            n_err++;
            $display("FAIL div[%0d] latency: got %0d expected 32", i, lat);
         end
         release32();
      end
   endtask

   task automatic test_special();
      logic [2:0]   ops [4] = '{3'b100, 3'b110, 3'b100, 3'b110};
      logic [W-1:0] va  [4] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
      logic [W-1:0] vb  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [W-1:0] exp [4] = '{32'hFFFF_FFFF, 32'h0000_0005, 32'h8000_0000, 32'h0000_0000};
      logic [W-1:0] res;
      int lat;
      for (int i = 0; i < 4; i++) begin
         run32(ops[i], va[i], vb[i], res, lat);
         n_cmp++;
         if (res !== exp[i]) begin
            n_err++;
            $display("FAIL special[%0d] result: got %h expected %h", i, res, exp[i]);
         end
         n_cmp++;
         if (lat !== 0) begin
            n_err++;
            $display("FAIL special[%0d] latency: got %0d edges expected 0", i, lat);
         end
         release32();
      end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] res;
      int lat;
      run32(3'b000, 32'd3, 32'd3, res, lat);
      n_cmp++;
      if (res !== 32'h9 || lat !== 32) begin
         n_err++;
         $display("FAIL bp result: got %h lat %0d expected 00000009 lat 32", res, lat);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge i_clk);
         n_cmp++;
         if (o_c !== 32'h9 || o_valid !== 1'b1 || o_ready !== 1'b0) begin
            n_err++;
            $display("FAIL bp hold[%0d]: c=%h valid=%b ready=%b expected 00000009 1 0",
                     i, o_c, o_valid, o_ready);
         end
      end
      i_ready = 1'b1;
      @(negedge i_clk);
      i_ready = 1'b0;
      n_cmp++;
      if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
         n_err++;
         $display("FAIL bp release: valid=%b ready=%b expected 0 1", o_valid, o_ready);
      end
   endtask

   task automatic test_kill();
      logic saw_valid = 1'b0;
      @(negedge i_clk);
      i_valid = 1'b1; i_op = 3'b101; i_a = 32'd100; i_b = 32'd7;
      @(negedge i_clk);
      i_valid = 1'b0;
      repeat (10) @(negedge i_clk);
      i_kill = 1'b1;
      @(negedge i_clk);
      i_kill = 1'b0;
      n_cmp++;
      if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_c !== 32'h9) begin
         n_err++;
         $display("FAIL kill: ready=%b valid=%b c=%h expected 1 0 00000009", o_ready, o_valid, o_c);
      end
      for (int i = 0; i < 40; i++) begin
         @(negedge i_clk);
         if (o_valid) saw_valid = 1'b1;
      end
      n_cmp++;
      if (saw_valid !== 1'b0) begin
         n_err++;
         $display("FAIL kill no_valid: o_valid seen=%b expected 0", saw_valid);
      end
   endtask

   task automatic test_reset_abort();
      logic [W-1:0] res;
      int lat;
      @(negedge i_clk);
      i_valid = 1'b1; i_op = 3'b101; i_a = 32'd100; i_b = 32'd7;
      @(negedge i_clk);
      i_valid = 1'b0;
      repeat (10) @(negedge i_clk);
      i_rst_n = 1'b0;
      #1;
      n_cmp++;
      if (o_valid !== 1'b0 || o_c !== '0 || o_ready !== 1'b1) begin
         n_err++;
         $display("FAIL rst_abort: valid=%b c=%h ready=%b expected 0 0 1", o_valid, o_c, o_ready);
      end
      @(negedge i_clk);
      i_rst_n = 1'b1;
      run32(3'b000, 32'd2, 32'd2, res, lat);
      n_cmp++;
      if (res !== 32'h4 || lat !== 32) begin
         n_err++;
         $display("FAIL post_reset mul: got %h lat %0d expected 00000004 lat 32", res, lat);
      end
      release32();
   endtask

   task automatic test_kill_idle();
      logic saw_valid = 1'b0;
      @(negedge i_clk);
      i_valid = 1'b1; i_kill = 1'b1; i_op = 3'b000; i_a = 32'd1; i_b = 32'd1;
      @(negedge i_clk);
      i_valid = 1'b0; i_kill = 1'b0;
      n_cmp++;
      if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
         n_err++;
         $display("FAIL kill_idle: ready=%b valid=%b expected 1 0", o_ready, o_valid);
      end
      for (int i = 0; i < 40; i++) begin
         @(negedge i_clk);
         if (o_valid) saw_valid = 1'b1;
      end
      n_cmp++;
      if (saw_valid !== 1'b0) begin
         n_err++;
         $display("FAIL kill_idle no_valid: o_valid seen=%b expected 0", saw_valid);
      end
   endtask

   task automatic test_width8();
      logic [2:0] ops [2] = '{3'b011, 3'b100};
      logic [7:0] va  [2] = '{8'h10, 8'h80};
      logic [7:0] vb  [2] = '{8'h10, 8'hFF};
      logic [7:0] exp [2] = '{8'h01, 8'h80};
      int         elat [2] = '{8, 0};
      int lat;
      for (int i = 0; i < 2; i++) begin
         @(negedge i_clk);
         v8 = 1'b1; op8 = ops[i]; a8 = va[i]; b8 = vb[i];
         @(negedge i_clk);
         v8 = 1'b0; a8 = ~va[i]; b8 = ~vb[i];
         lat = 0;
         while (!o_valid8 && lat < 100) begin
            @(negedge i_clk);
            lat++;
         end
         n_cmp++;
         if (o_c8 !== exp[i]) begin
            n_err++;
            $display("FAIL w8[%0d] result: got %h expected %h", i, o_c8, exp[i]);
         end
         n_cmp++;
         if (lat !== elat[i]) begin
            n_err++;
            $display("FAIL w8[%0d] latency: got %0d expected %0d", i, lat, elat[i]);
         end
         @(negedge i_clk);
         r8 = 1'b1;
         @(negedge i_clk);
         r8 = 1'b0;
      end
   endtask

   initial begin
      i_rst_n = 1'b0;
      i_valid = 1'b0; i_kill = 1'b0; i_ready = 1'b0;
      i_op = '0; i_a = '0; i_b = '0;
      v8 = 1'b0; k8 = 1'b0; r8 = 1'b0;
      op8 = '0; a8 = '0; b8 = '0;
      repeat (3) @(negedge i_clk);
      test_reset();
      i_rst_n = 1'b1;
      test_mul();
      test_div();
      test_special();
      test_backpressure();
      test_kill();
      test_reset_abort();
      test_kill_idle();
      test_width8();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
